sd_dat_rx_ctrl: RTL and testbench
=================================

Name: sd_dat_rx_ctrl

Overview:
- Sequences the SD DAT-line receive stream for host-to-card data (CMD53 write).
- Arms the stream receiver once per block and forwards received bytes into the card data buffer with address generation.
- Collects the per-block CRC result and hands it to the CRC-status token transmitter.
- Repeats for multi-block transfers, ending on block count, CRC error, abort or timeout.

Parameters:
- ADDR_W, 17, width of the buffer byte address.
- TIMEOUT_CYCLES, 1048576, clocks allowed from arming a block to its end (rx_all_strobe).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- xfer_start  in  1  one-cycle pulse to begin a transfer
- xfer_block_len  in  9  bytes per block, 1..511; 0 is illegal
- xfer_block_count  in  9  number of blocks; 0 = unlimited, until abort
- xfer_addr  in  ADDR_W  first buffer address
- xfer_addr_inc  in  1  1 = incrementing address, 0 = fixed address
- xfer_abort  in  1  one-cycle pulse, CMD52 I/O abort
- rx_read_strobe  out  1  one-cycle arm pulse to the stream receiver
- rx_data_count  out  9  byte count for the armed block
- rx_byte_strobe  in  1  receiver got a byte
- rx_byte  in  8  received byte
- rx_all_strobe  in  1  receiver finished the block, including CRC
- rx_crc_ok  in  1  CRC result, valid while rx_all_strobe is high
- buf_we  out  1  buffer write enable
- buf_addr  out  ADDR_W  buffer write address
- buf_wdata  out  8  buffer write data
- status_strobe  out  1  one-cycle request to send a CRC-status token
- status_crc_ok  out  1  token kind: 1 = positive (010), 0 = negative (101)
- status_done  in  1  token transmitter finished, including busy
- busy  out  1  transfer in progress
- blocks_done  out  9  blocks received with good CRC
- done_strobe  out  1  one-cycle end-of-transfer pulse
- done_crc_err  out  1  end cause flag, valid while done_strobe is high
- done_aborted  out  1  end cause flag, valid while done_strobe is high
- done_timeout  out  1  end cause flag, valid while done_strobe is high
- done_len_err  out  1  end cause flag, valid while done_strobe is high

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-transfer abandons the transfer with no done_strobe.
- States: IDLE, ARM, RECV, STATUS, FINISH.
- IDLE:
  - xfer_start with xfer_block_len==0 gives done_strobe plus done_len_err on the next cycle and stays IDLE.
  - Any other xfer_start latches len, count and addr, clears blocks_done, sets busy, then goes to ARM.
  - xfer_start while busy is ignored.
- ARM:
  - Drives rx_read_strobe=1 for one cycle, with rx_data_count=latched len in the same cycle.
  - Loads the byte counter with len and the timeout counter with TIMEOUT_CYCLES, then goes to RECV.
- RECV, per rx_byte_strobe:
  - Next cycle: buf_we=1, buf_wdata=rx_byte, buf_addr=current address.
  - The address then increments if xfer_addr_inc=1, wrapping modulo 2^ADDR_W.
  - The byte counter decrements; strobes arriving at counter 0 produce no write.
- RECV, on rx_all_strobe:
  - Latches rx_crc_ok and goes to STATUS.
  - If CRC is good, blocks_done increments (saturates at 511).
- STATUS:
  - Pulses status_strobe one cycle, with status_crc_ok=latched CRC, then waits for status_done.
  - On status_done: CRC bad goes to FINISH(crc_err).
  - On status_done with good CRC: if count!=0 and blocks_done==count, goes to FINISH(ok); otherwise goes to ARM.
- FINISH: one-cycle done_strobe with cause flags, busy=0, then IDLE.
- Abort: xfer_abort in any non-IDLE state goes to FINISH(aborted) next cycle.
  - Abort wins over a simultaneous rx_all_strobe or status_done.
  - No status_strobe is issued after an abort.
  - Abort in IDLE is ignored.
- Simultaneous rx_byte_strobe and rx_all_strobe: the byte is written, then STATUS.
- Cause flags: exactly one is set on an error end; none are set on a normal end.

Optional Feature:
- SD_RX_TIMEOUT_EN defined:
  - The timeout counter decrements in RECV.
  - Reaching 0 goes to FINISH(timeout) with no status token.
- Not defined:
  - No counter is built, done_timeout is tied 0, and RECV waits indefinitely.
  - TIMEOUT_CYCLES is unused.

Decomposition:
- Package sd_dat_pkg holds:
  - the state enum type
  - SD_MAX_BLOCK_LEN=511
  - CRC-status token constants 3'b010 and 3'b101
  - the done-cause struct
- Optional sub-module sd_dat_addr_gen: address register with load, increment enable and fixed/increment mode.

Test Plan:
- Single block: len=4, count=1, addr=0x100, inc=1, bytes A1 B2 C3 D4, crc_ok=1.
  - Writes to 0x100..0x103.
  - status_strobe with status_crc_ok=1, then done_strobe with no flags and blocks_done=1.
- Multi-block: len=2, count=3, inc=0, addr=0x20.
  - Three rx_read_strobe pulses, 6 writes all at 0x20.
  - done_strobe after the third status_done, blocks_done=3.
- CRC error on block 2 of 3:
  - status_strobe with status_crc_ok=0.
  - done_strobe with done_crc_err=1, blocks_done=1, no third arm.
- Abort in RECV on the same cycle as rx_all_strobe: no status_strobe, done_aborted=1, busy falls.
- len=0: done_len_err=1 one cycle after xfer_start; no rx_read_strobe.
- Timeout: with SD_RX_TIMEOUT_EN and TIMEOUT_CYCLES=16, no rx_all_strobe → done_timeout=1 exactly 16 clocks after entering RECV.

Source files
------------

// File: rtl/sd_dat_pkg.sv
// Shared types and constants for the SD DAT-line receive controller.
package sd_dat_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRecv,
    StStatus,
    StFinish
  } sd_rx_state_e;

  localparam int unsigned SD_MAX_BLOCK_LEN = 511;

  localparam logic [2:0] SD_CRC_TOKEN_POS = 3'b010;
  localparam logic [2:0] SD_CRC_TOKEN_NEG = 3'b101;

  typedef struct packed {
    logic crc_err;
    logic aborted;
    logic timeout;
    logic len_err;
  } sd_done_cause_t;

endpackage

// File: rtl/sd_dat_addr_gen.sv
// Buffer byte-address register: load with mode, then step in incrementing or fixed mode.
module sd_dat_addr_gen #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              load_inc_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inc_q, inc_d;

  always_comb begin
    addr_d = addr_q;
    inc_d  = inc_q;
    if (load_i) begin
      addr_d = load_addr_i;
      inc_d  = load_inc_i;
    end else if (step_i && inc_q) begin
      // Wraps naturally modulo 2^ADDR_W.
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      inc_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      inc_q  <= inc_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sd_dat_rx_ctrl.sv
// Host-to-card DAT receive sequencer: arms the receiver per block, writes bytes to the buffer,
// and hands each block's CRC result to the status-token sender. Timeout needs SD_RX_TIMEOUT_EN.
module sd_dat_rx_ctrl
  import sd_dat_pkg::*;
#(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              xfer_start,
  input  logic [8:0]        xfer_block_len,
  input  logic [8:0]        xfer_block_count,
  input  logic [ADDR_W-1:0] xfer_addr,
  input  logic              xfer_addr_inc,
  input  logic              xfer_abort,
  output logic              rx_read_strobe,
  output logic [8:0]        rx_data_count,
  input  logic              rx_byte_strobe,
  input  logic [7:0]        rx_byte,
  input  logic              rx_all_strobe,
  input  logic              rx_crc_ok,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [7:0]        buf_wdata,
  output logic              status_strobe,
  output logic              status_crc_ok,
  input  logic              status_done,
  output logic              busy,
  output logic [8:0]        blocks_done,
  output logic              done_strobe,
  output logic              done_crc_err,
  output logic              done_aborted,
  output logic              done_timeout,
  output logic              done_len_err
);

  sd_rx_state_e      state_q, state_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        count_q, count_d;
  logic [8:0]        byte_cnt_q, byte_cnt_d;
  logic [8:0]        blocks_done_q, blocks_done_d;
  logic              busy_q, busy_d;
  logic              rx_read_strobe_q, rx_read_strobe_d;
  logic [8:0]        rx_data_count_q, rx_data_count_d;
  logic              buf_we_q, buf_we_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_wdata_q, buf_wdata_d;
  logic              status_strobe_q, status_strobe_d;
  logic              status_crc_ok_q, status_crc_ok_d;
  logic              done_strobe_q, done_strobe_d;
  sd_done_cause_t    cause_q, cause_d;

  logic              addr_load;
  logic              addr_step;
  logic [ADDR_W-1:0] cur_addr;

`ifdef SD_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  sd_dat_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock      (clock),
    .reset      (reset),
    .load_i     (addr_load),
    .load_addr_i(xfer_addr),
    .load_inc_i (xfer_addr_inc),
    .step_i     (addr_step),
    .addr_o     (cur_addr)
  );

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    count_d          = count_q;
    byte_cnt_d       = byte_cnt_q;
    blocks_done_d    = blocks_done_q;
    busy_d           = busy_q;
    rx_read_strobe_d = 1'b0;
    rx_data_count_d  = rx_data_count_q;
    buf_we_d         = 1'b0;
    buf_addr_d       = buf_addr_q;
    buf_wdata_d      = buf_wdata_q;
    status_strobe_d  = 1'b0;
    status_crc_ok_d  = status_crc_ok_q;
    done_strobe_d    = 1'b0;
    cause_d          = '0;
    addr_load        = 1'b0;
    addr_step        = 1'b0;
`ifdef SD_RX_TIMEOUT_EN
    tmo_d            = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (xfer_start) begin
          if (xfer_block_len == 9'd0) begin
            done_strobe_d   = 1'b1;
            cause_d.len_err = 1'b1;
          end else begin
            len_d            = xfer_block_len;
            count_d          = xfer_block_count;
            blocks_done_d    = '0;
            busy_d           = 1'b1;
            addr_load        = 1'b1;
            rx_read_strobe_d = 1'b1;
            rx_data_count_d  = xfer_block_len;
            state_d          = StArm;
          end
        end
      end

      StArm: begin
        if (xfer_abort) begin
          state_d         = StFinish;
          done_strobe_d   = 1'b1;
          busy_d          = 1'b0;
          cause_d.aborted = 1'b1;
        end else begin
          byte_cnt_d = len_q;
`ifdef SD_RX_TIMEOUT_EN
          tmo_d      = TmoW'(TIMEOUT_CYCLES);
`endif
          state_d    = StRecv;
        end
      end

      StRecv: begin
        if (xfer_abort) begin
          state_d         = StFinish;
          done_strobe_d   = 1'b1;
          busy_d          = 1'b0;
          cause_d.aborted = 1'b1;
        end else begin
          // Strobes beyond the armed length are dropped.
          if (rx_byte_strobe && (byte_cnt_q != 9'd0)) begin
            buf_we_d    = 1'b1;
            buf_wdata_d = rx_byte;
            buf_addr_d  = cur_addr;
            addr_step   = 1'b1;
            byte_cnt_d  = byte_cnt_q - 9'd1;
          end
          if (rx_all_strobe) begin
            status_strobe_d = 1'b1;
            status_crc_ok_d = rx_crc_ok;
            if (rx_crc_ok && (blocks_done_q != 9'(SD_MAX_BLOCK_LEN))) begin
              blocks_done_d = blocks_done_q + 9'd1;
            end
            state_d = StStatus;
          end
`ifdef SD_RX_TIMEOUT_EN
          else if (tmo_q <= TmoW'(1)) begin
            state_d         = StFinish;
            done_strobe_d   = 1'b1;
            busy_d          = 1'b0;
            cause_d.timeout = 1'b1;
          end else begin
            tmo_d = tmo_q - TmoW'(1);
          end
`endif
        end
      end

      StStatus: begin
        if (xfer_abort) begin
          state_d         = StFinish;
          done_strobe_d   = 1'b1;
          busy_d          = 1'b0;
          cause_d.aborted = 1'b1;
        end else if (status_done) begin
          if (!status_crc_ok_q) begin
            state_d         = StFinish;
            done_strobe_d   = 1'b1;
            busy_d          = 1'b0;
            cause_d.crc_err = 1'b1;
          end else if ((count_q != 9'd0) && (blocks_done_q == count_q)) begin
            state_d       = StFinish;
            done_strobe_d = 1'b1;
            busy_d        = 1'b0;
          end else begin
            rx_read_strobe_d = 1'b1;
            rx_data_count_d  = len_q;
            state_d          = StArm;
          end
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      len_q            <= '0;
      count_q          <= '0;
      byte_cnt_q       <= '0;
      blocks_done_q    <= '0;
      busy_q           <= 1'b0;
      rx_read_strobe_q <= 1'b0;
      rx_data_count_q  <= '0;
      buf_we_q         <= 1'b0;
      buf_addr_q       <= '0;
      buf_wdata_q      <= '0;
      status_strobe_q  <= 1'b0;
      status_crc_ok_q  <= 1'b0;
      done_strobe_q    <= 1'b0;
      cause_q          <= '0;
`ifdef SD_RX_TIMEOUT_EN
      tmo_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      count_q          <= count_d;
      byte_cnt_q       <= byte_cnt_d;
      blocks_done_q    <= blocks_done_d;
      busy_q           <= busy_d;
      rx_read_strobe_q <= rx_read_strobe_d;
      rx_data_count_q  <= rx_data_count_d;
      buf_we_q         <= buf_we_d;
      buf_addr_q       <= buf_addr_d;
      buf_wdata_q      <= buf_wdata_d;
      status_strobe_q  <= status_strobe_d;
      status_crc_ok_q  <= status_crc_ok_d;
      done_strobe_q    <= done_strobe_d;
      cause_q          <= cause_d;
`ifdef SD_RX_TIMEOUT_EN
      tmo_q            <= tmo_d;
`endif
    end
  end

  assign rx_read_strobe = rx_read_strobe_q;
  assign rx_data_count  = rx_data_count_q;
  assign buf_we         = buf_we_q;
  assign buf_addr       = buf_addr_q;
  assign buf_wdata      = buf_wdata_q;
  assign status_strobe  = status_strobe_q;
  assign status_crc_ok  = status_crc_ok_q;
  assign busy           = busy_q;
  assign blocks_done    = blocks_done_q;
  assign done_strobe    = done_strobe_q;
  assign done_crc_err   = cause_q.crc_err;
  assign done_aborted   = cause_q.aborted;
  assign done_len_err   = cause_q.len_err;
`ifdef SD_RX_TIMEOUT_EN
  assign done_timeout   = cause_q.timeout;
`else
  assign done_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dat_rx_ctrl.sv
// Directed self-checking bench for sd_dat_rx_ctrl (timeout case only with SD_RX_TIMEOUT_EN).
module tb_sd_dat_rx_ctrl;

  localparam int unsigned AW = 17;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          xfer_start = 1'b0;
  logic [8:0]    xfer_block_len = '0;
  logic [8:0]    xfer_block_count = '0;
  logic [AW-1:0] xfer_addr = '0;
  logic          xfer_addr_inc = 1'b0;
  logic          xfer_abort = 1'b0;
  logic          rx_read_strobe;
  logic [8:0]    rx_data_count;
  logic          rx_byte_strobe = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          rx_all_strobe = 1'b0;
  logic          rx_crc_ok = 1'b0;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_wdata;
  logic          status_strobe;
  logic          status_crc_ok;
  logic          status_done = 1'b0;
  logic          busy;
  logic [8:0]    blocks_done;
  logic          done_strobe;
  logic          done_crc_err;
  logic          done_aborted;
  logic          done_timeout;
  logic          done_len_err;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_data[$];
  int            arm_cnt = 0;
  int            stat_cnt = 0;

  always #5 clock = ~clock;

  sd_dat_rx_ctrl #(
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .xfer_start      (xfer_start),
    .xfer_block_len  (xfer_block_len),
    .xfer_block_count(xfer_block_count),
    .xfer_addr       (xfer_addr),
    .xfer_addr_inc   (xfer_addr_inc),
    .xfer_abort      (xfer_abort),
    .rx_read_strobe  (rx_read_strobe),
    .rx_data_count   (rx_data_count),
    .rx_byte_strobe  (rx_byte_strobe),
    .rx_byte         (rx_byte),
    .rx_all_strobe   (rx_all_strobe),
    .rx_crc_ok       (rx_crc_ok),
    .buf_we          (buf_we),
    .buf_addr        (buf_addr),
    .buf_wdata       (buf_wdata),
    .status_strobe   (status_strobe),
    .status_crc_ok   (status_crc_ok),
    .status_done     (status_done),
    .busy            (busy),
    .blocks_done     (blocks_done),
    .done_strobe     (done_strobe),
    .done_crc_err    (done_crc_err),
    .done_aborted    (done_aborted),
    .done_timeout    (done_timeout),
    .done_len_err    (done_len_err)
  );

  // Passive observer of one-cycle pulses and buffer writes.
  always @(negedge clock) begin
    if (!reset) begin
      if (buf_we) begin
        wr_addr.push_back(buf_addr);
        wr_data.push_back(buf_wdata);
      end
      if (rx_read_strobe) arm_cnt++;
      if (status_strobe) stat_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return rx_read_strobe;
      1:       return status_strobe;
      default: return done_strobe;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (!sig_of(which) && n < 100) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, sig_of(which)}, 32'd1);
  endtask

  task automatic clear_obs();
    wr_addr.delete();
    wr_data.delete();
    arm_cnt  = 0;
    stat_cnt = 0;
  endtask

  task automatic start(input logic [8:0] len, input logic [8:0] cnt, input logic [AW-1:0] a,
                       input logic inc);
    xfer_block_len   = len;
    xfer_block_count = cnt;
    xfer_addr        = a;
    xfer_addr_inc    = inc;
    xfer_start       = 1'b1;
    tick();
    xfer_start       = 1'b0;
  endtask

  // One block: wait for arm, stream n bytes (byte 0 in data[7:0]), end, answer the status token.
  task automatic send_block(input int n, input logic [31:0] data, input logic crc);
    wait_for(0, "arm");
    check_eq("rx_data_count", {23'd0, rx_data_count}, n);
    tick();
    for (int i = 0; i < n; i++) begin
      rx_byte_strobe = 1'b1;
      rx_byte        = data[8*i+:8];
      tick();
    end
    rx_byte_strobe = 1'b0;
    rx_all_strobe  = 1'b1;
    rx_crc_ok      = crc;
    tick();
    rx_all_strobe  = 1'b0;
    wait_for(1, "status_strobe");
    check_eq("status_crc_ok", {31'd0, status_crc_ok}, {31'd0, crc});
    tick();
    tick();
    status_done = 1'b1;
    tick();
    status_done = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {done_crc_err, done_aborted, done_timeout, done_len_err};
  endfunction

  initial begin
    repeat (3) tick();
    check_eq("rst busy", {31'd0, busy}, 0);
    check_eq("rst arm", {31'd0, rx_read_strobe}, 0);
    check_eq("rst we", {31'd0, buf_we}, 0);
    check_eq("rst done", {31'd0, done_strobe}, 0);
    check_eq("rst blocks", {23'd0, blocks_done}, 0);
    reset = 1'b0;
    tick();

    // Single incrementing block.
    clear_obs();
    start(9'd4, 9'd1, 17'h100, 1'b1);
    check_eq("single busy", {31'd0, busy}, 1);
    send_block(4, 32'hD4C3B2A1, 1'b1);
    wait_for(2, "single done");
    check_eq("single flags", {28'd0, flags()}, 0);
    check_eq("single blocks", {23'd0, blocks_done}, 1);
    check_eq("single busy end", {31'd0, busy}, 0);
    tick();
    check_eq("single nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check_eq("single addr", {15'd0, wr_addr[i]}, 32'h100 + i);
    end
    if (wr_data.size() == 4) begin
      check_eq("single d0", {24'd0, wr_data[0]}, 32'hA1);
      check_eq("single d3", {24'd0, wr_data[3]}, 32'hD4);
    end

    // Three blocks at a fixed address.
    clear_obs();
    start(9'd2, 9'd3, 17'h20, 1'b0);
    send_block(2, 32'h2211, 1'b1);
    send_block(2, 32'h4433, 1'b1);
    send_block(2, 32'h6655, 1'b1);
    wait_for(2, "multi done");
    check_eq("multi flags", {28'd0, flags()}, 0);
    check_eq("multi blocks", {23'd0, blocks_done}, 3);
    tick();
    check_eq("multi arms", arm_cnt, 3);
    check_eq("multi nwr", wr_addr.size(), 6);
    for (int i = 0; i < wr_addr.size(); i++) begin
      check_eq("multi addr", {15'd0, wr_addr[i]}, 32'h20);
    end
    if (wr_data.size() == 6) check_eq("multi d5", {24'd0, wr_data[5]}, 32'h66);

    // CRC error on the second of three blocks.
    clear_obs();
    start(9'd2, 9'd3, 17'h40, 1'b1);
    send_block(2, 32'hBBAA, 1'b1);
    send_block(2, 32'hDDCC, 1'b0);
    wait_for(2, "crc done");
    check_eq("crc flags", {28'd0, flags()}, 4'b1000);
    check_eq("crc blocks", {23'd0, blocks_done}, 1);
    repeat (4) tick();
    check_eq("crc arms", arm_cnt, 2);

    // Abort coinciding with the end of a block.
    clear_obs();
    start(9'd2, 9'd0, 17'h0, 1'b1);
    wait_for(0, "abort arm");
    tick();
    rx_byte_strobe = 1'b1;
    rx_byte        = 8'h5A;
    tick();
    rx_byte        = 8'hA5;
    tick();
    rx_byte_strobe = 1'b0;
    rx_all_strobe  = 1'b1;
    rx_crc_ok      = 1'b1;
    xfer_abort     = 1'b1;
    tick();
    rx_all_strobe  = 1'b0;
    xfer_abort     = 1'b0;
    check_eq("abort done", {31'd0, done_strobe}, 1);
    check_eq("abort flags", {28'd0, flags()}, 4'b0100);
    check_eq("abort busy", {31'd0, busy}, 0);
    repeat (4) tick();
    check_eq("abort status", stat_cnt, 0);

    // Zero length is rejected on the next cycle.
    clear_obs();
    start(9'd0, 9'd1, 17'h0, 1'b1);
    check_eq("len0 done", {31'd0, done_strobe}, 1);
    check_eq("len0 flags", {28'd0, flags()}, 4'b0001);
    check_eq("len0 busy", {31'd0, busy}, 0);
    repeat (3) tick();
    check_eq("len0 arms", arm_cnt, 0);

    // Abort while idle does nothing.
    xfer_abort = 1'b1;
    tick();
    xfer_abort = 1'b0;
    check_eq("idle abort", {31'd0, done_strobe}, 0);

`ifdef SD_RX_TIMEOUT_EN
    clear_obs();
    start(9'd4, 9'd1, 17'h0, 1'b1);
    wait_for(0, "tmo arm");
    tick();
    repeat (15) tick();
    check_eq("tmo early", {31'd0, done_strobe}, 0);
    tick();
    check_eq("tmo done", {31'd0, done_strobe}, 1);
    check_eq("tmo flags", {28'd0, flags()}, 4'b0010);
    check_eq("tmo status", stat_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
